// File: rtl/multdiv_pkg.sv
// -----------------------------------------------------------------------------
// multdiv_pkg
// Shared definitions for the sequential signed multiply/divide unit:
//   - state_e : FSM state encoding (IDLE, MULT, DIV, DONE)
//   - op_e    : operation type (OP_MULT, OP_DIV)
//   - mult_latency / div_latency : accept-to-result_rdy latency in cycles
// Configuration macro: MULTDIV_BOOTH4_EN (radix-4 Booth multiply when defined).
// -----------------------------------------------------------------------------
package multdiv_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_e;

   typedef enum logic {
      OP_MULT = 1'b0,
      OP_DIV  = 1'b1
   } op_e;

   // Cycles from the accepting edge to the result_rdy pulse. One cycle per
   // iteration in MULT/DIV plus the cycle spent in DONE.
   function automatic int mult_latency(input int width);
`ifdef MULTDIV_BOOTH4_EN
      return width / 2 + 1;
`else
      return width + 1;
`endif
   endfunction

   function automatic int div_latency(input int width);
      return width + 1;
   endfunction

endpackage

// File: rtl/booth_recoder.sv
// -----------------------------------------------------------------------------
// booth_recoder
// Radix-4 Booth partial-product selector. Maps a 3-bit multiplier window
// {b[2i+1], b[2i], b[2i-1]} to {0, +-1, +-2} x multiplicand.
// Only instantiated when MULTDIV_BOOTH4_EN is defined.
// Ports:
//   window_i [2:0]        multiplier bit window
//   mcand_i  [WIDTH-1:0]  signed multiplicand
//   pp_o     [WIDTH+1:0]  signed partial product (two guard bits for 2x)
// -----------------------------------------------------------------------------
module booth_recoder #(
   parameter int WIDTH = 32
) (
   input  logic [2:0]       window_i,
   input  logic [WIDTH-1:0] mcand_i,
   output logic [WIDTH+1:0] pp_o
);

   logic [WIDTH+1:0] m1;
   logic [WIDTH+1:0] m2;

   assign m1 = {{2{mcand_i[WIDTH-1]}}, mcand_i};
   assign m2 = {mcand_i[WIDTH-1], mcand_i, 1'b0};

   always_comb begin
      pp_o = '0;
      case (window_i)
         3'b001, 3'b010: pp_o = m1;
         3'b011:         pp_o = m2;
         3'b100:         pp_o = -m2;
         3'b101, 3'b110: pp_o = -m1;
         default:        pp_o = '0;
      endcase
   end

endmodule

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
// Sequential signed multiply / divide. Multiply is shift-add on magnitudes
// (or radix-4 Booth on signed operands when MULTDIV_BOOTH4_EN is defined);
// divide is restoring division on magnitudes, truncating toward zero.
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   start_mult, start_div  operation requests (multiply wins if both high)
//   operand_A, operand_B   operands, sampled only on the accepting edge
//   result                 product low half or quotient, held between ops
//   exception              overflow / divide-by-zero, valid with result_rdy
//   result_rdy             one-cycle pulse, high while the FSM is in DONE
//   busy                   high while in MULT or DIV
//   state_o                FSM state, for debug and assertion binding
// Handshake: a start is taken on any rising edge where the unit is not busy
// (IDLE or DONE); starts while busy are dropped. There is no backpressure on
// the result side: result/exception must be captured on result_rdy.
// Configuration macro: MULTDIV_BOOTH4_EN.
// -----------------------------------------------------------------------------
module multdiv_unit
   import multdiv_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start_mult,
   input  logic             start_div,
   input  logic [WIDTH-1:0] operand_A,
   input  logic [WIDTH-1:0] operand_B,
   output logic [WIDTH-1:0] result,
   output logic             exception,
   output logic             result_rdy,
   output logic             busy,
   output state_e           state_o
);

   localparam int MULT_ITERS = mult_latency(WIDTH) - 1;
   localparam int DIV_ITERS  = div_latency(WIDTH) - 1;
`ifdef MULTDIV_BOOTH4_EN
   // Booth partial sums reach +-2x multiplicand: two guard bits.
   localparam int ACC_W = WIDTH + 2;
`else
   localparam int ACC_W = WIDTH + 1;
`endif

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [ACC_W-1:0] acc_q, acc_d;      // product high half / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;        // multiplier->product low / dividend->quotient
   logic [WIDTH-1:0] mcand_q;           // multiplicand or divisor
   logic             neg_q;             // final result must be negated
   logic [WIDTH-1:0] result_q;
   logic             exception_q;
   logic             result_rdy_q;
   logic             busy_q;

   // ---------------- request decode ----------------
   logic             accept;
   op_e              req_op;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic             ops_neg;
   logic             div_zero;
   logic             last_iter;

   assign accept   = ((state_q == IDLE) || (state_q == DONE)) && (start_mult || start_div);
   assign req_op   = start_mult ? OP_MULT : OP_DIV;
   assign mag_a    = operand_A[WIDTH-1] ? -operand_A : operand_A;
   assign mag_b    = operand_B[WIDTH-1] ? -operand_B : operand_B;
   assign ops_neg  = operand_A[WIDTH-1] ^ operand_B[WIDTH-1];
   assign div_zero = (operand_B == '0);

   assign last_iter = (state_q == MULT) ? (cnt_q == CNT_W'(MULT_ITERS - 1))
                                        : (cnt_q == CNT_W'(DIV_ITERS - 1));

   // ---------------- divide step ----------------
   // Partial remainder is always below the divisor magnitude (<= 2^(WIDTH-1)),
   // so after the shift it fits in WIDTH bits and bit WIDTH of the trial
   // subtraction is a clean borrow flag.
   logic [WIDTH:0] div_shift, div_trial;
   logic           div_borrow;

   assign div_shift  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign div_trial  = div_shift - {1'b0, mcand_q};
   assign div_borrow = div_trial[WIDTH];

   // ---------------- multiply step ----------------
`ifdef MULTDIV_BOOTH4_EN
   logic             b_q, b_d;          // multiplier bit shifted out last step
   logic [ACC_W-1:0] booth_pp, booth_sum;

   booth_recoder #(.WIDTH(WIDTH)) u_booth_recoder (
      .window_i ({lo_q[1:0], b_q}),
      .mcand_i  (mcand_q),
      .pp_o     (booth_pp)
   );

   assign booth_sum = acc_q + booth_pp;
`else
   logic [WIDTH:0] mul_sum;

   assign mul_sum = acc_q + {1'b0, (lo_q[0] ? mcand_q : {WIDTH{1'b0}})};
`endif

   always_comb begin
      acc_d = acc_q;
      lo_d  = lo_q;
`ifdef MULTDIV_BOOTH4_EN
      b_d   = b_q;
`endif
      if (state_q == DIV) begin
         acc_d = ACC_W'(div_borrow ? div_shift : div_trial);
         lo_d  = {lo_q[WIDTH-2:0], ~div_borrow};
      end else begin
`ifdef MULTDIV_BOOTH4_EN
         acc_d = {{2{booth_sum[ACC_W-1]}}, booth_sum[ACC_W-1:2]};
         lo_d  = {booth_sum[1:0], lo_q[WIDTH-1:2]};
         b_d   = lo_q[1];
`else
         acc_d = {1'b0, mul_sum[WIDTH:1]};
         lo_d  = {mul_sum[0], lo_q[WIDTH-1:1]};
`endif
      end
   end

   // ---------------- final result formation ----------------
   // Evaluated from the step outputs so the last iteration and the result
   // write share one edge.
   logic [2*WIDTH-1:0] prod_raw, prod_s;
   logic               mul_exc;
   logic [WIDTH-1:0]   quo_s;
   logic               div_exc;

   assign prod_raw = {acc_d[WIDTH-1:0], lo_d};
`ifdef MULTDIV_BOOTH4_EN
   assign prod_s   = prod_raw;
`else
   assign prod_s   = neg_q ? -prod_raw : prod_raw;
`endif
   // Overflow: upper half plus result sign bit are not all equal.
   assign mul_exc  = ~((&prod_s[2*WIDTH-1:WIDTH-1]) | ~(|prod_s[2*WIDTH-1:WIDTH-1]));
   assign quo_s    = neg_q ? -lo_d : lo_d;
   // A positive quotient with the top bit set only arises from MIN / -1.
   assign div_exc  = ~neg_q & lo_d[WIDTH-1];

   // ---------------- FSM and datapath registers ----------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         acc_q        <= '0;
         lo_q         <= '0;
         mcand_q      <= '0;
         neg_q        <= 1'b0;
         result_q     <= '0;
         exception_q  <= 1'b0;
         result_rdy_q <= 1'b0;
         busy_q       <= 1'b0;
`ifdef MULTDIV_BOOTH4_EN
         b_q          <= 1'b0;
`endif
      end else begin
         result_rdy_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               if (accept) begin
                  exception_q <= 1'b0;
                  cnt_q       <= '0;
                  acc_q       <= '0;
                  neg_q       <= ops_neg;
                  if (req_op == OP_MULT) begin
                     state_q <= MULT;
                     busy_q  <= 1'b1;
`ifdef MULTDIV_BOOTH4_EN
                     lo_q    <= operand_B;
                     mcand_q <= operand_A;
                     b_q     <= 1'b0;
`else
                     lo_q    <= mag_b;
                     mcand_q <= mag_a;
`endif
                  end else if (div_zero) begin
                     state_q      <= DONE;
                     result_q     <= '0;
                     exception_q  <= 1'b1;
                     result_rdy_q <= 1'b1;
                  end else begin
                     state_q <= DIV;
                     busy_q  <= 1'b1;
                     lo_q    <= mag_a;
                     mcand_q <= mag_b;
                  end
               end
            end
            MULT, DIV: begin
               acc_q <= acc_d;
               lo_q  <= lo_d;
               cnt_q <= cnt_q + 1'b1;
`ifdef MULTDIV_BOOTH4_EN
               b_q   <= b_d;
`endif
               if (last_iter) begin
                  state_q      <= DONE;
                  busy_q       <= 1'b0;
                  result_rdy_q <= 1'b1;
                  if (state_q == MULT) begin
                     result_q    <= prod_s[WIDTH-1:0];
                     exception_q <= mul_exc;
                  end else begin
                     result_q    <= quo_s;
                     exception_q <= div_exc;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign result     = result_q;
   assign exception  = exception_q;
   assign result_rdy = result_rdy_q;
   assign busy       = busy_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
// Randomized and directed stimulus for multdiv_unit (WIDTH=32). The driver
// pushes the reference-model answer and its due cycle into a queue when it
// issues an operation; an independent monitor pops and compares on every
// result_rdy pulse.
// -----------------------------------------------------------------------------
module tb_multdiv_unit;
   import multdiv_pkg::*;

   localparam int W = 32;
`ifdef MULTDIV_BOOTH4_EN
   localparam int MUL_LAT = 17;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;
   localparam logic [W-1:0] MIN_VAL = 32'h8000_0000;

   // ---------------- clock / reset ----------------
   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         start_mult = 1'b0;
   logic         start_div = 1'b0;
   logic [W-1:0] operand_A = '0;
   logic [W-1:0] operand_B = '0;
   logic [W-1:0] result;
   logic         exception;
   logic         result_rdy;
   logic         busy;
   state_e       state_o;

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   multdiv_unit #(.WIDTH(W)) dut (
      .clock      (clock),
      .reset      (reset),
      .start_mult (start_mult),
      .start_div  (start_div),
      .operand_A  (operand_A),
      .operand_B  (operand_B),
      .result     (result),
      .exception  (exception),
      .result_rdy (result_rdy),
      .busy       (busy),
      .state_o    (state_o)
   );

   // ---------------- scoreboard ----------------
   int           checks = 0;
   int           passes = 0;
   logic [W-1:0] exp_q[$];
   logic         exp_exc_q[$];
   int           exp_cyc_q[$];
   string        exp_name_q[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Reference model: plain signed arithmetic, returns {exception, result}.
   function automatic logic [W:0] ref_mult(input logic [W-1:0] a, input logic [W-1:0] b);
      longint p;
      logic [W-1:0] r;
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[W-1:0];
      return {(p != longint'($signed(r))), r};
   endfunction

   function automatic logic [W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
      int sa, sb, q;
      sa = $signed(a);
      sb = $signed(b);
      if (sb == 0) return {1'b1, 32'h0};
      if (a == MIN_VAL && sb == -1) return {1'b1, MIN_VAL};
      q = sa / sb;
      return {1'b0, q[W-1:0]};
   endfunction

   // Monitor: every result_rdy pulse must match the oldest expectation.
   always @(negedge clock) begin
      if (!reset && result_rdy) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result_rdy", 64'd1, 64'd0);
         end else begin
            logic [W-1:0] e_res;
            logic         e_exc;
            int           e_cyc;
            string        e_name;
            e_res  = exp_q.pop_front();
            e_exc  = exp_exc_q.pop_front();
            e_cyc  = exp_cyc_q.pop_front();
            e_name = exp_name_q.pop_front();
            check({e_name, "_result"}, 64'(result), 64'(e_res));
            check({e_name, "_exception"}, 64'(exception), 64'(e_exc));
            check({e_name, "_latency"}, 64'(cyc), 64'(e_cyc));
         end
      end
   end

   // ---------------- driver ----------------
   // Called at a falling edge; the start is taken on the next rising edge.
   task automatic issue(input bit do_mult, input bit do_div, input logic [W-1:0] a,
                        input logic [W-1:0] b, input string name);
      int          guard;
      logic [W:0]  exp;
      int          lat;
      bit          goes_busy;
      guard = 0;
      while (busy && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      if (busy) check({name, "_wait_not_busy"}, 64'd1, 64'd0);
      operand_A  = a;
      operand_B  = b;
      start_mult = do_mult;
      start_div  = do_div;
      if (do_mult) begin
         exp = ref_mult(a, b);
         lat = MUL_LAT;
      end else begin
         exp = ref_div(a, b);
         lat = (b == '0) ? 1 : DIV_LAT;
      end
      goes_busy = do_mult || (b != '0);
      exp_q.push_back(exp[W-1:0]);
      exp_exc_q.push_back(exp[W]);
      exp_cyc_q.push_back(cyc + lat);
      exp_name_q.push_back(name);
      @(negedge clock);
      start_mult = 1'b0;
      start_div  = 1'b0;
      operand_A  = $urandom;
      operand_B  = $urandom;
      check({name, "_busy_after_accept"}, 64'(busy), 64'(goes_busy));
   endtask

   function automatic logic [W-1:0] pick_operand();
      logic [W-1:0] v;
      case ($urandom_range(0, 6))
         0:       v = '0;
         1:       v = '1;
         2:       v = MIN_VAL;
         3:       v = W'($urandom_range(1, 20));
         4:       v = -W'($urandom_range(1, 20));
         5:       v = W'($urandom_range(0, 32'hFFFF));
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      int guard;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("reset_result", 64'(result), 64'd0);
      check("reset_exception", 64'(exception), 64'd0);
      check("reset_result_rdy", 64'(result_rdy), 64'd0);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_state", 64'(state_o), 64'(IDLE));

      // Start on the first edge after reset release.
      reset = 1'b0;
      issue(1, 0, 32'd7, -32'd6, "mul_7_x_m6");
      issue(1, 0, 32'h0001_0000, 32'h0001_0000, "mul_overflow");
      issue(0, 1, -32'd7, 32'd2, "div_m7_by_2");
      issue(0, 1, 32'd5, 32'd0, "div_by_zero");
      issue(0, 1, MIN_VAL, 32'hFFFF_FFFF, "div_min_by_m1");
      issue(1, 1, 32'd9, 32'd3, "both_starts_mult_wins");
      issue(0, 1, MIN_VAL, 32'd1, "div_min_by_1");
      issue(1, 0, MIN_VAL, 32'hFFFF_FFFF, "mul_min_x_m1");

      // start_div during a multiply is dropped.
      issue(1, 0, 32'd3, 32'd4, "mul_3_x_4");
      repeat (8) @(negedge clock);
      operand_A = 32'd100;
      operand_B = 32'd5;
      start_div = 1'b1;
      @(negedge clock);
      start_div = 1'b0;
      check("ignored_div_busy", 64'(busy), 64'd1);
      check("ignored_div_state", 64'(state_o), 64'(MULT));

      // Reset in the middle of a divide: no result for it.
      guard = 0;
      while (busy && guard < 200) begin
         @(negedge clock);
         guard++;
      end
      operand_A = 32'd100;
      operand_B = 32'd7;
      start_div = 1'b1;
      @(negedge clock);
      start_div = 1'b0;
      repeat (11) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("midreset_busy", 64'(busy), 64'd0);
      check("midreset_result", 64'(result), 64'd0);
      check("midreset_state", 64'(state_o), 64'(IDLE));
      reset = 1'b0;
      issue(1, 0, 32'd2, 32'd3, "mul_after_reset");

      // Randomized mix, issued back-to-back whenever the unit is free.
      for (int i = 0; i < 60; i++) begin
         int kind;
         kind = $urandom_range(0, 9);
         if (kind < 4)      issue(1, 0, pick_operand(), pick_operand(), "rand_mul");
         else if (kind < 9) issue(0, 1, pick_operand(), pick_operand(), "rand_div");
         else               issue(1, 1, pick_operand(), pick_operand(), "rand_both");
      end

      guard = 0;
      while (exp_q.size() > 0 && guard < 500) begin
         @(negedge clock);
         guard++;
      end
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      repeat (5) @(negedge clock);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passes, checks);
      $fatal(1);
   end

endmodule

// File: doc/multdiv_unit.md
MULTDIV_UNIT -- requirements
Module: multdiv_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; must be even and at least 4.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 Port clock, input, 1: the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port start_mult, input, 1: request a signed multiply of operand_A by operand_B.
REQ-006 Port start_div, input, 1: request a signed divide, operand_A divided by operand_B.
REQ-007 Port operand_A, input, WIDTH: first operand; sampled only on the accepting edge.
REQ-008 Port operand_B, input, WIDTH: second operand; sampled only on the accepting edge.
REQ-009 Port result, output, WIDTH: product low bits or quotient; held until the next accepted start.
REQ-010 Port exception, output, 1: overflow or divide-by-zero flag; valid together with result.
REQ-011 Port result_rdy, output, 1: one-cycle pulse marking result and exception valid.
REQ-012 Port busy, output, 1: high while an operation is in flight.

Function
REQ-013 FSM states and transitions:
- IDLE -> MULT on an accepted start_mult.
- IDLE -> DIV on an accepted start_div.
- MULT or DIV -> DONE when the counter reaches its terminal count.
- DONE -> IDLE unconditionally.
REQ-014 A start is accepted only in IDLE or DONE; starts in MULT or DIV are ignored with no side effect.
REQ-015 If start_mult and start_div are high on the same edge, only the multiply is started.
REQ-016 Multiply: radix-2 shift-add on magnitudes, sign applied at the end; result = product[WIDTH-1:0].
REQ-017 Multiply result_rdy is high exactly WIDTH+1 cycles after the accepting edge.
REQ-018 Multiply exception = 1 when the 2*WIDTH-bit product is not the sign-extension of result.
REQ-019 Divide: restoring division on magnitudes; quotient truncates toward zero; the remainder is discarded.
REQ-020 Divide result_rdy is high exactly WIDTH+1 cycles after the accepting edge.
REQ-021 Divide with operand_B == 0: result = 0, exception = 1, result_rdy on the very next cycle; the FSM bypasses DIV and goes straight to DONE.
REQ-022 Divide of the most negative value by -1: result = 100…0, exception = 1, at normal latency.
REQ-023 busy is high from the cycle after acceptance through the cycle before DONE.
REQ-024 A start accepted in DONE is back-to-back: its result_rdy pulse for the old result still occurs that cycle.
REQ-025 Exception is cleared on every accepted start and updated only in DONE.

Reset
REQ-026 While reset is high:
- FSM returns to IDLE and the counter clears.
- result = 0, exception = 0, result_rdy = 0, busy = 0.
REQ-027 Reset mid-operation abandons the operation; no result_rdy is produced for it.
REQ-028 A start on the first edge after reset deasserts is accepted normally.

Configuration
REQ-029 Macro MULTDIV_BOOTH4_EN selects the multiply algorithm.
- Defined: multiply uses radix-4 Booth recoding, latency WIDTH/2+1 cycles.
- Undefined: radix-2 multiply per REQ-016/017.
- Divide behaviour is identical in both builds.

Structure
REQ-030 Shared package multdiv_pkg holds:
- the FSM state encoding (IDLE, MULT, DIV, DONE);
- operation type constants (OP_MULT, OP_DIV);
- the latency constants as functions of WIDTH.
REQ-031 One sub-module, booth_recoder: maps a 3-bit multiplier window to {0, ±1, ±2}×multiplicand; instantiated only under MULTDIV_BOOTH4_EN.

Verification (WIDTH=32)
REQ-032 Multiply 7 × -6 -> result 0xFFFFFFD6, exception 0, result_rdy at cycle 33 (cycle 17 with MULTDIV_BOOTH4_EN).
REQ-033 Multiply 0x00010000 × 0x00010000 -> result 0x00000000, exception 1.
REQ-034 Divide -7 / 2 -> result 0xFFFFFFFD, exception 0, result_rdy at cycle 33; divide 5 / 0 -> result 0, exception 1, result_rdy at cycle 1.
REQ-035 Divide 0x80000000 / 0xFFFFFFFF -> result 0x80000000, exception 1.
REQ-036 start_div pulsed at cycle 10 during a multiply started at cycle 0 -> ignored; multiply 3 × 4 completes with result 12.
REQ-037 reset asserted at cycle 12 of a divide, then multiply 2 × 3 started -> no result_rdy for the divide; result 6 at latency.
